modadd_arbiter: RTL and testbench
=================================

Name: modadd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 256-bit modular add/subtract unit (a±b mod params.n) among NUM_REQ requesters in the ECC point-arithmetic layer.
- Accepts at most one operation per cycle, registers the result with the requester ID, and returns it on one shared response channel with valid/ready backpressure.
- Keeps a wrapping count of completed operations for debug and performance measurement.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- ID_W, 2, width of requester ID; must equal $clog2(NUM_REQ).
- CNT_W, 32, width of the completed-operation counter.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ×256  packed operand A per requester; must be < params.n.
- req_b  in  NUM_REQ×256  packed operand B per requester; must be < params.n.
- req_op  in  NUM_REQ  per-requester op select: 0 = a+b mod n, 1 = a−b mod n.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_sum  out  256  modular result.
- op_count  out  CNT_W  completed (handed-off) results; wraps to 0.

Behaviour:
- Reset (asynchronous, Reset_n=0): rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0, rr_ptr=0, state=EMPTY. req_ready is combinationally 0 while Reset_n=0.
- States: EMPTY (output register empty) and FULL (result held).
- accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending with wrap; the first asserted index is granted.
  - req_ready[g]=1 only if accept and a grant exists; all other bits are 0.
  - A request accepted by handshake in cycle t is transferred (req_valid[g] & req_ready[g]).
- On transfer:
  - rsp_sum ← add(req_a[g], req_b[g], req_op[g]); rsp_id ← g; rsp_valid ← 1.
  - rr_ptr ← (g+1) mod NUM_REQ.
  - Latency: result is visible the cycle after transfer.
- Without transfer:
  - If rsp_valid & rsp_ready: rsp_valid ← 0 and the state goes to EMPTY.
  - Otherwise the output register holds and rr_ptr holds.
- Simultaneous drain and accept: a new result replaces the old one in the same edge and rsp_valid stays 1. This gives full throughput of one op per cycle when rsp_ready is held at 1.
- Transitions:
  - EMPTY→FULL on transfer.
  - FULL→FULL on transfer, or on hold (rsp_ready=0).
  - FULL→EMPTY on drain with no transfer.
- op_count increments by 1 on every rsp_valid & rsp_ready, and wraps from 2^CNT_W−1 to 0.
- Backpressure: while FULL and rsp_ready=0, req_ready=0 and outputs are stable. The requester must keep req_valid and its operands stable until ready.
- Fairness: a requester with a continuously asserted request is granted within NUM_REQ transfers.
- Arithmetic: identical to the shared add unit.
  - Subtract: if a−b underflows, the result is a−b+n.
  - Add: if a+b ≥ n, the result is a+b−n.
  - Behaviour for operands ≥ n is undefined.
- Reset mid-operation: the held result is discarded, nothing is reported, and the arbiter restarts at requester 0.

Decomposition:
- The modulus n comes from the existing shared params package.
- Add to params: typedef fe_t (logic [255:0]) and localparam MODOP_ADD=1'b0, MODOP_SUB=1'b1.
- Instantiate the existing add unit once as the datapath sub-module; arbitration and the output register stay in this module.
- A separate rr_arbiter sub-module (grant and pointer) is natural and reusable.

Test Plan:
- Reset, then requester 0 only, a=5, b=7, op=0 → next cycle rsp_valid=1, rsp_id=0, rsp_sum=12; op_count=1 after the handshake.
- Requester 2: a=3, b=5, op=1 → rsp_sum=n−2. Then a=n−1, b=2, op=0 → rsp_sum=1.
- All 4 requesters valid continuously with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,…, one result per cycle, each req_ready pulsing once every 4 cycles.
- Result held with rsp_ready=0 for 5 cycles → rsp_sum and rsp_id stable, req_ready=0. On release, the next grant goes to the requester after the last grant.
- Preload op_count near 2^CNT_W−1 via a forced counter or a small CNT_W=4 build, then run 17 ops → op_count wraps to 1.
- Assert Reset_n=0 mid-stream while FULL → rsp_valid=0 immediately and op_count=0. After release, the first grant goes to the lowest valid index starting from requester 0.

Source files
------------

// File: rtl/modadd_arbiter_pkg.sv
// Field types, modulus and shared enums for the modular add/subtract arbiter.
// The modulus is the secp256k1 prime used across the ECC point-arithmetic layer.
package modadd_arbiter_pkg;
   localparam int FE_W = 256;
   typedef logic [FE_W-1:0] fe_t;

   localparam fe_t P_MOD =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   localparam logic MODOP_ADD = 1'b0;
   localparam logic MODOP_SUB = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/modadd_arbiter_addunit.sv
// Combinational 256-bit modular add/subtract: a+b mod n or a-b mod n.
// Operands are assumed to already be reduced (< n).
module modadd_arbiter_addunit
   import modadd_arbiter_pkg::*;
(
   input  fe_t  i_a,
   input  fe_t  i_b,
   input  logic i_op,
   output fe_t  o_res
);
   logic [FE_W:0] w_sum;
   logic [FE_W:0] w_diff;
   fe_t           w_sum_red;
   fe_t           w_diff_fix;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   // Both corrections fit in 256 bits because the true result is below n.
   assign w_sum_red  = w_sum[FE_W-1:0] - P_MOD;
   assign w_diff_fix = w_diff[FE_W-1:0] + P_MOD;

   always_comb begin
      if (i_op == MODOP_ADD) begin
         o_res = (w_sum >= {1'b0, P_MOD}) ? w_sum_red : w_sum[FE_W-1:0];
      end else begin
         o_res = w_diff[FE_W] ? w_diff_fix : w_diff[FE_W-1:0];
      end
   end
endmodule

// File: rtl/modadd_arbiter_rr.sv
// Round-robin grant search starting at the pointer, ascending with wrap.
// The pointer moves just past the granted index whenever a transfer happens.
module modadd_arbiter_rr #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic               o_gnt_any,
   output logic [ID_W-1:0]    o_gnt_id
);
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_ptr_next;
   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_idx;

   always_comb begin
      o_gnt_any = 1'b0;
      o_gnt_id  = '0;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!o_gnt_any && i_req[w_idx]) begin
            o_gnt_any = 1'b1;
            o_gnt_id  = w_idx;
         end
      end
   end

   assign w_ptr_next = (o_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : o_gnt_id + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= w_ptr_next;
      end
   end
endmodule

// File: rtl/modadd_arbiter.sv
// Shares one modular add/subtract unit among NUM_REQ requesters and returns
// registered results on a single valid/ready channel with a completion counter.
module modadd_arbiter
   import modadd_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic [NUM_REQ-1:0][FE_W-1:0] i_req_a,
   input  logic [NUM_REQ-1:0][FE_W-1:0] i_req_b,
   input  logic [NUM_REQ-1:0]           i_req_op,
   output logic                         o_rsp_valid,
   input  logic                         i_rsp_ready,
   output logic [ID_W-1:0]              o_rsp_id,
   output logic [FE_W-1:0]              o_rsp_sum,
   output logic [CNT_W-1:0]             o_op_count
);
   state_t          r_state;
   state_t          w_state_next;
   logic [ID_W-1:0] r_rsp_id;
   fe_t             r_rsp_sum;
   logic [CNT_W-1:0] r_op_count;
   logic            w_gnt_any;
   logic [ID_W-1:0] w_gnt_id;
   logic            w_drain;
   logic            w_transfer;
   fe_t             w_res;

   modadd_arbiter_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     (i_req_valid),
      .i_advance (w_transfer),
      .o_gnt_any (w_gnt_any),
      .o_gnt_id  (w_gnt_id)
   );

   modadd_arbiter_addunit u_add (
      .i_a   (i_req_a[w_gnt_id]),
      .i_b   (i_req_b[w_gnt_id]),
      .i_op  (i_req_op[w_gnt_id]),
      .o_res (w_res)
   );

   // A drain frees the register in the same edge, so accept and drain can overlap.
   assign w_drain    = (r_state == ST_FULL) && i_rsp_ready;
   assign w_transfer = i_rst_n && w_gnt_any && ((r_state == ST_EMPTY) || w_drain);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_transfer) w_state_next = ST_FULL;
         ST_FULL:  if (w_drain && !w_transfer) w_state_next = ST_EMPTY;
         default:  w_state_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      o_rsp_valid = (r_state == ST_FULL);
      o_req_ready = '0;
      if (w_transfer) begin
         o_req_ready = NUM_REQ'(1) << w_gnt_id;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_id   <= '0;
         r_rsp_sum  <= '0;
         r_op_count <= '0;
      end else begin
         if (w_transfer) begin
            r_rsp_id  <= w_gnt_id;
            r_rsp_sum <= w_res;
         end
         if (w_drain) begin
            r_op_count <= r_op_count + 1'b1;
         end
      end
   end

   assign o_rsp_id   = r_rsp_id;
   assign o_rsp_sum  = r_rsp_sum;
   assign o_op_count = r_op_count;
endmodule

// File: tb/tb_modadd_arbiter.sv
// Randomized and directed checks of the modular add/subtract arbiter against
// a transaction-level reference model; uses a 4-bit counter build to reach wrap.
module tb_modadd_arbiter;
   localparam int NR = 4;
   localparam int CW = 4;
   localparam logic [255:0] N =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_ready;
   logic [NR-1:0]        req_op;
   logic [NR-1:0][255:0] req_a;
   logic [NR-1:0][255:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [255:0]         rsp_sum;
   logic [CW-1:0]        op_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic         m_valid;
   int           m_id;
   logic [255:0] m_sum;
   int           m_ptr;
   int           m_count;
   int           m_g;
   logic [NR-1:0] m_rdy;

   always #5 clk = ~clk;

   modadd_arbiter #(.NUM_REQ(NR), .ID_W(2), .CNT_W(CW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_op    (req_op),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_id    (rsp_id),
      .o_rsp_sum   (rsp_sum),
      .o_op_count  (op_count)
   );

   function automatic logic [255:0] ref_op(input logic [255:0] a, input logic [255:0] b,
                                           input logic op);
      logic [257:0] t;
      if (op) t = {2'b0, a} + {2'b0, N} - {2'b0, b};
      else    t = {2'b0, a} + {2'b0, b};
      return 256'(t % {2'b0, N});
   endfunction

   function automatic logic [255:0] rand_fe();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = N - 1;
         default: if (v >= N) v = v - N;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_id = 0; m_sum = '0; m_ptr = 0; m_count = 0; m_g = -1; m_rdy = '0;
   endtask

   // Grant decision from the current inputs: first valid requester at or after the pointer.
   task automatic model_comb();
      int idx;
      m_g = -1;
      for (int k = 0; k < NR; k++) begin
         idx = (m_ptr + k) % NR;
         if (m_g < 0 && req_valid[idx]) m_g = idx;
      end
      m_rdy = '0;
      if ((!m_valid || rsp_ready) && m_g >= 0) m_rdy[m_g] = 1'b1;
   endtask

   task automatic clk_edge();
      model_comb();
      @(posedge clk);
      if (m_valid && rsp_ready) m_count = (m_count + 1) % (1 << CW);
      if (m_rdy != '0) begin
         m_sum   = ref_op(req_a[m_g], req_b[m_g], req_op[m_g]);
         m_id    = m_g;
         m_valid = 1'b1;
         m_ptr   = (m_g + 1) % NR;
         $display("xfer t=%0t req=%0d op=%0d sum_lo=%h", $time, m_g, req_op[m_g], m_sum[31:0]);
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin req_a[i] = 256'd1; req_b[i] = 256'd1; end
      req_op = '0;
      model_reset();
      #3;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
      checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
      checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", op_count); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      req_valid = '0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      req_valid = 4'b0001; req_a[0] = 256'd5; req_b[0] = 256'd7; req_op[0] = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready: got %b want 0001", req_ready); end
      clk_edge();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL add_id: got %0d want 0", rsp_id); end
      checks++; if (rsp_sum !== 256'd12) begin errors++; $display("FAIL add_sum: got %h want 12", rsp_sum); end
      req_valid = '0; rsp_ready = 1'b1;
      clk_edge();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid: got %b want 0", rsp_valid); end
      checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL add_count: got %0d want 1", op_count); end
   endtask

   task automatic test_sub_wrap();
      logic [255:0] exp_v;
      req_valid = 4'b0100; req_a[2] = 256'd3; req_b[2] = 256'd5; req_op[2] = 1'b1; rsp_ready = 1'b1;
      clk_edge();
      exp_v = N - 256'd2;
      checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL sub_id: got %0d want 2", rsp_id); end
      checks++; if (rsp_sum !== exp_v) begin errors++; $display("FAIL sub_sum: got %h want %h", rsp_sum, exp_v); end
      req_a[2] = N - 256'd1; req_b[2] = 256'd2; req_op[2] = 1'b0;
      clk_edge();
      checks++; if (rsp_sum !== 256'd1) begin errors++; $display("FAIL addwrap_sum: got %h want 1", rsp_sum); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL addwrap_valid: got %b want 1", rsp_valid); end
      checks++; if (op_count !== 4'd2) begin errors++; $display("FAIL addwrap_count: got %0d want 2", op_count); end
      req_valid = '0;
      clk_edge();
      checks++; if (op_count !== 4'd3) begin errors++; $display("FAIL sub_drain_count: got %0d want 3", op_count); end
   endtask

   task automatic test_round_robin();
      int exp_id;
      exp_id = m_ptr;
      req_valid = '1; rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NR; i++) begin
            req_a[i] = rand_fe(); req_b[i] = rand_fe(); req_op[i] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         checks++;
         if (req_ready !== (NR'(1) << exp_id)) begin
            errors++; $display("FAIL rr_ready: cycle %0d got %b want id %0d", c, req_ready, exp_id);
         end
         clk_edge();
         checks++; if (rsp_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_id: got %0d want %0d", rsp_id, exp_id); end
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid: got %b want 1", rsp_valid); end
         checks++; if (rsp_sum !== m_sum) begin errors++; $display("FAIL rr_sum: got %h want %h", rsp_sum, m_sum); end
         exp_id = (exp_id + 1) % NR;
      end
   endtask

   task automatic test_backpressure();
      int h_id;
      logic [255:0] h_sum;
      int h_cnt;
      h_id = m_id; h_sum = m_sum; h_cnt = m_count;
      req_valid = '1; rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_ready: got %b want 0000", req_ready); end
         clk_edge();
         checks++; if (rsp_id !== 2'(h_id) || rsp_sum !== h_sum || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got id %0d sum %h valid %b want id %0d sum %h valid 1",
                               rsp_id, rsp_sum, rsp_valid, h_id, h_sum);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== (NR'(1) << ((h_id + 1) % NR))) begin
         errors++; $display("FAIL bp_release_ready: got %b want id %0d", req_ready, (h_id + 1) % NR);
      end
      clk_edge();
      checks++; if (rsp_id !== 2'((h_id + 1) % NR)) begin errors++; $display("FAIL bp_release_id: got %0d want %0d", rsp_id, (h_id + 1) % NR); end
      checks++; if (op_count !== CW'((h_cnt + 1) % 16)) begin errors++; $display("FAIL bp_count: got %0d want %0d", op_count, (h_cnt + 1) % 16); end
   endtask

   task automatic test_count_wrap();
      int c0;
      req_valid = '1; rsp_ready = 1'b1;
      clk_edge();
      c0 = m_count;
      for (int k = 0; k < 17; k++) begin
         clk_edge();
         checks++;
         if (op_count !== CW'((c0 + k + 1) % 16)) begin
            errors++; $display("FAIL wrap_count: step %0d got %0d want %0d", k, op_count, (c0 + k + 1) % 16);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || m_rdy[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_a[i] = rand_fe(); req_b[i] = rand_fe(); req_op[i] = 1'($urandom_range(0, 1));
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         model_comb();
         @(negedge clk);
         checks++; if (req_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready: got %b want %b", req_ready, m_rdy); end
         clk_edge();
         checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", rsp_valid, m_valid); end
         checks++; if (rsp_id !== 2'(m_id)) begin errors++; $display("FAIL rnd_id: got %0d want %0d", rsp_id, m_id); end
         checks++; if (rsp_sum !== m_sum) begin errors++; $display("FAIL rnd_sum: got %h want %h", rsp_sum, m_sum); end
         checks++; if (op_count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", op_count, m_count); end
      end
   endtask

   task automatic test_reset_mid();
      req_valid = '1; rsp_ready = 1'b0;
      clk_edge();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
      checks++; if (op_count !== '0) begin errors++; $display("FAIL midrst_count: got %0d want 0", op_count); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_grant: got %b want 0010", req_ready); end
      clk_edge();
      checks++; if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_rsp: got id %0d valid %b want id 1 valid 1", rsp_id, rsp_valid);
      end
      checks++; if (rsp_sum !== m_sum) begin errors++; $display("FAIL midrst_sum: got %h want %h", rsp_sum, m_sum); end
   endtask

   initial begin
      req_valid = '0; req_op = '0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0;
      test_reset();
      test_add();
      test_sub_wrap();
      test_round_robin();
      test_backpressure();
      test_count_wrap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
